// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared action bit indices, FSM encoding and sizing helper for the Booth accumulator
package booth_pkg;

    localparam int ACT_NEG = 0;
    localparam int ACT_DBL = 1;
    localparam int ACT_SGL = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must reach NDIG itself, hence the +1.
    function automatic int cnt_width(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// rtl/booth_pp_select.sv - maps one Booth action onto a signed partial product 0/+-M/+-2M
module booth_pp_select
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_m,
    input  logic [2:0]       i_action,
    output logic [WIDTH+1:0] o_pp,
    output logic             o_illegal
);

    logic [WIDTH+1:0] w_m_ext;
    logic [WIDTH+1:0] w_mag;

    assign w_m_ext   = {{2{i_m[WIDTH-1]}}, i_m};
    assign o_illegal = i_action[ACT_SGL] & i_action[ACT_DBL];

    // Illegal single+double is forced to zero magnitude; negating zero yields zero, never -1.
    always_comb begin
        w_mag = '0;
        if (!o_illegal) begin
            if (i_action[ACT_SGL]) begin
                w_mag = w_m_ext;
            end else if (i_action[ACT_DBL]) begin
                w_mag = w_m_ext << 1;
            end
        end
    end

    assign o_pp = i_action[ACT_NEG] ? (~w_mag + 1'b1) : w_mag;

endmodule

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - consumes radix-4 Booth actions LSB digit first and accumulates M*Y
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               abort,
    input  logic               act_valid,
    input  logic [2:0]         action,
    output logic               act_ready,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               err
);

    localparam int NDIG = WIDTH / 2;
    localparam int CW   = cnt_width(NDIG);
    localparam int EXT  = 2*WIDTH - (WIDTH + 2);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               r_prod_valid;
    logic               r_err;

    logic               w_xfer;
    logic               w_last;
    logic               w_start_acc;
    logic [WIDTH+1:0]   w_pp;
    logic               w_illegal;
    logic [2*WIDTH-1:0] w_pp_ext;
    logic [2*WIDTH-1:0] w_acc_nxt;

    booth_pp_select #(
        .WIDTH (WIDTH)
    ) u_pp_select (
        .i_m       (r_m),
        .i_action  (action),
        .o_pp      (w_pp),
        .o_illegal (w_illegal)
    );

    assign act_ready   = (r_state == ST_ACCUM);
    assign prod_valid  = r_prod_valid;
    assign product     = r_product;
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;

    // Abort suppresses every other event, including a transfer offered in the same cycle.
    assign w_xfer      = act_valid && act_ready && !abort;
    assign w_last      = w_xfer && (r_cnt == LAST_DIG);
    assign w_start_acc = (r_state == ST_IDLE) && start && !abort;

    assign w_pp_ext  = {{EXT{w_pp[WIDTH+1]}}, w_pp};
    assign w_acc_nxt = r_acc + (w_pp_ext << {r_cnt, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_prod_valid && prod_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_product    <= '0;
            r_prod_valid <= 1'b0;
            r_err        <= 1'b0;
        end else if (abort) begin
            r_prod_valid <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_m   <= multiplicand;
                r_acc <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_xfer) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end
            if (w_last) begin
                r_product    <= w_acc_nxt;
                r_prod_valid <= 1'b1;
            end
            if ((r_state == ST_DONE) && prod_ready) begin
                r_prod_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb/tb_booth_pp_accumulator.sv - self-checking bench for booth_pp_accumulator against an M*Y reference
module tb_booth_pp_accumulator;

    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / 2;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic               abort;
    logic               act_valid;
    logic [2:0]         action;
    logic               act_ready;
    logic               prod_valid;
    logic               prod_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               err;

    int                 n_vec;
    int                 n_miss;
    logic [31:0]        last_product;

    booth_pp_accumulator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .abort        (abort),
        .act_valid    (act_valid),
        .action       (action),
        .act_ready    (act_ready),
        .prod_valid   (prod_valid),
        .prod_ready   (prod_ready),
        .product      (product),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Radix-4 Booth digit value of y for digit d, with y[-1] = 0.
    function automatic int dig_val(input logic [15:0] y, input int d);
        logic [16:0] ye;
        ye = {y, 1'b0};
        return -2 * int'(ye[2*d+2]) + int'(ye[2*d+1]) + int'(ye[2*d]);
    endfunction

    // Reference encoder: [2]=single, [1]=double, [0]=neg.
    function automatic logic [2:0] enc(input logic [15:0] y, input int d);
        logic [16:0] ye;
        ye = {y, 1'b0};
        case (dig_val(y, d))
            1:       return 3'b100;
            2:       return 3'b010;
            -1:      return 3'b101;
            -2:      return 3'b011;
            default: return ye[2*d+2] ? 3'b001 : 3'b000;
        endcase
    endfunction

    task automatic run(input logic [15:0] m, input logic [15:0] y, input bit gap,
                       input int rwait, input int bad, input int abort_at, input bit chk_lat);
        int          d;
        int          cyc;
        bit          tog;
        longint      e;
        logic [31:0] exp_p;
        e = longint'($signed(m)) * longint'($signed(y));
        if (bad >= 0) begin
            e = e - longint'(dig_val(y, bad)) * longint'($signed(m)) * (longint'(1) << (2*bad));
        end
        exp_p = e[31:0];

        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 16'($urandom);
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
        check("act_ready_in_accum", act_ready, 1);

        d   = 0;
        cyc = 1;
        tog = 1'b1;
        while (d < NDIG && cyc < 200) begin
            if (d == abort_at) begin
                act_valid = 1'b1;
                action    = enc(y, d);
                abort     = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                act_valid = 1'b0;
                check("abort_to_idle", busy, 0);
                check("abort_act_ready", act_ready, 0);
                check("abort_no_prod_valid", prod_valid, 0);
                repeat (NDIG) begin
                    @(negedge clk);
                    check("abort_quiet", prod_valid, 0);
                end
                return;
            end
            act_valid = gap ? tog : 1'b1;
            tog       = ~tog;
            action    = act_valid ? ((d == bad) ? 3'b110 : enc(y, d)) : 3'($urandom);
            if (act_valid && act_ready) d++;
            @(negedge clk);
            cyc++;
        end
        act_valid = 1'b0;
        check("digits_accepted", d, NDIG);
        if (chk_lat) check("latency_cycle", cyc, NDIG + 1);
        check("prod_valid", prod_valid, 1);
        check("product", product, exp_p);
        check("err_flag", err, (bad >= 0));
        last_product = product;

        for (int w = 0; w < rwait; w++) begin
            prod_ready = 1'b0;
            if (w == 0) begin
                start        = 1'b1;
                multiplicand = 16'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            check("hold_prod_valid", prod_valid, 1);
            check("hold_product", product, exp_p);
            check("hold_busy", busy, 1);
        end
        prod_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        prod_ready = 1'b0;
        start      = 1'b0;
        check("handshake_drop_valid", prod_valid, 0);
        check("start_at_done_exit_ignored", busy, 0);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        abort        = 1'b0;
        act_valid    = 1'b0;
        action       = '0;
        prod_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_act_ready", act_ready, 0);
        check("rst_prod_valid", prod_valid, 0);
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_act_ready", act_ready, 0);

        run(16'd3, 16'd5, 1'b0, 0, -1, -1, 1'b1);
        check("p_3x5", last_product, 32'h0000000F);
        run(16'h8000, 16'h8000, 1'b0, 1, -1, -1, 1'b1);
        check("p_min_x_min", last_product, 32'h40000000);
        run(16'd5, 16'hFFFF, 1'b0, 0, -1, -1, 1'b1);
        check("p_5_x_m1", last_product, 32'hFFFFFFFB);
        run(16'hFFF9, 16'hFFFE, 1'b1, 3, -1, -1, 1'b0);
        check("p_m7_x_m2", last_product, 32'h0000000E);

        run(16'h1234, 16'h0F5A, 1'b0, 0, 2, -1, 1'b1);
        @(negedge clk);
        check("err_sticky", err, 1);
        run(16'd9, 16'd11, 1'b0, 0, -1, -1, 1'b1);
        check("p_after_err", last_product, 32'd99);

        run(16'h0101, 16'h7777, 1'b0, 0, -1, 3, 1'b0);
        run(16'hFF00, 16'h00FF, 1'b1, 2, -1, -1, 1'b0);

        run(16'h4321, 16'hA5A5, 1'b0, 0, 5, -1, 1'b1);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            act_valid = 1'b1;
            action    = 3'b100;
            @(negedge clk);
        end
        act_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_act_ready", act_ready, 0);
        check("arst_prod_valid", prod_valid, 0);
        check("arst_product", product, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'hFFFD, 16'h0007, 1'b0, 0, -1, -1, 1'b1);
        check("p_after_reset", last_product, 32'hFFFFFFEB);

        for (int k = 0; k < 20; k++) begin
            run(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, NDIG - 1) : -1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
